bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
// Read-side sequencer for one SB_RAM256x16 block used as a lookup table or waveform store.
// Walks a programmed address window (base, length, stride) and drives RADDR/RE/RCLKE.
// Accounts for the one-cycle RAM read latency and presents words on a valid/ready stream.
// Sits between the RAM instance and any downstream consumer (DAC feeder, simulator probe, DSP).
// PARAMETERS
// ADDR_W    8   RAM address width (256 words)
// DATA_W    16  RAM word width
// FIFO_D    2   output buffer depth; fixed at 2, other values unsupported
// PORTS
// clk        in   1       single clock; also drives RAM RCLK
// rst_n      in   1       asynchronous active-low reset
// start      in   1       one-cycle pulse; starts a pass, honoured only in IDLE
// stop       in   1       one-cycle pulse; abort request, honoured in RUN
// base_addr  in   ADDR_W  first address; sampled on accepted start
// length     in   9       words per pass, 1..256; 0 = no-op; sampled on start
// stride     in   ADDR_W  address increment, modulo 256; sampled on start
// loop       in   1       1 = restart at base_addr after last word; sampled on start
// raddr      out  ADDR_W  RAM read address
// read_en    out  1       RAM RE
// rclke      out  1       RAM RCLKE; equals read_en
// rdata      in   DATA_W  RAM RDATA; valid one clk after read_en sampled high
// m_data     out  DATA_W  stream data
// m_valid    out  1       stream valid
// m_ready    in   1       stream ready; transfer when m_valid & m_ready
// m_last     out  1       marks last word of each pass
// busy       out  1       high outside IDLE
// done       out  1       one-cycle pulse when a pass sequence ends (completion or stop)
// BEHAVIOUR
// - Reset values: raddr=0, read_en=0, rclke=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0.
// - Reset is asynchronous: FSM returns to IDLE, buffer flushes, in-flight read is discarded.
// - States:
//   - IDLE->RUN on start when length!=0. Loads addr=base_addr and remaining=length.
//   - IDLE with start and length==0: done pulses next cycle, state stays IDLE.
//   - RUN issues one read per cycle while (fifo_count + inflight) < 2.
//   - Each issued read: addr += stride (wraps mod 256), remaining -= 1.
//   - Final read issued (remaining==1): loop=1 reloads addr/remaining and stays in RUN;
//     loop=0 goes to DRAIN.
//   - RUN->DRAIN on stop. No further reads; the in-flight word is still captured.
//   - DRAIN->IDLE when inflight==0 and the buffer is empty. done pulses on that edge.
// - Latency: start at edge N -> read_en=1 at N+1 -> word in buffer at N+2 -> m_valid=1 from N+2.
//   One word per cycle sustained while m_ready=1.
// - rdata is captured on the edge after read_en was high. A tag bit carries m_last with each read.
// - AXI-style rules: m_data/m_last hold stable while m_valid & !m_ready.
//   m_valid never drops without a transfer, except on reset.
// - Simultaneous stop and final read in the same cycle: that read completes; go to DRAIN; done once.
// - Simultaneous push and pop on the buffer: occupancy is unchanged, and ordering is preserved.
// - start while busy is ignored. stop in IDLE or DRAIN is ignored.
// - raddr holds its last value when read_en=0.
// STRUCTURE
// - Package bram_rd_pkg:
//   - ADDR_W, DATA_W, LEN_W=9
//   - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} rd_state_t
//   - typedef struct packed {logic last; logic [DATA_W-1:0] data;} rd_word_t
// - Sub-module bram_rd_skid: 2-entry FIFO of rd_word_t.
//   Exposes count, push, pop, valid/ready. Credit check uses its count.
// - Top module holds the FSM, address/remaining counters, inflight flag and tag register.
// TESTING
// Bench uses an SB_RAM256x16 model preloaded with mem[a] = {8'hA5, a}.
// 1. base=0x10, len=4, stride=1, loop=0, m_ready=1 -> data A510,A511,A512,A513.
//    m_last on A513. m_valid first at start+2. done 1 cycle after the last transfer.
// 2. base=0xFE, len=4, stride=1 -> A5FE,A5FF,A500,A501 (address wrap). m_last on A501.
// 3. base=0, len=8, m_ready toggling 1010 / held 0 for 5 cycles -> no loss, no duplicates.
//    Stable m_data while stalled. read_en=0 while the buffer plus in-flight word equals 2.
// 4. base=0x20, len=3, stride=0x10, loop=1, stop after 7 transfers ->
//    sequence A520,A530,A540 repeats with m_last every 3rd word.
//    The in-flight word is delivered, then done; busy=0.
// 5. start with len=0 -> read_en never asserts; done pulses once.
//    start during RUN leaves parameters unchanged.
// 6. rst_n low mid-RUN with m_valid=1 -> all outputs 0 immediately.
//    After release, a new start (base=0x40, len=2) yields A540,A541.

Source files
------------

// File: rtl/bram_rd_pkg.sv
`default_nettype none
// ============================================================================
// bram_rd_pkg : shared types and widths for the BRAM stream reader
// Rev 1.0
// ============================================================================
package bram_rd_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 9;
    localparam int FIFO_D = 2;
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } rd_word_t;

endpackage
`default_nettype wire

// File: rtl/bram_rd_skid.sv
`default_nettype none
// ============================================================================
// bram_rd_skid : two-entry output buffer for RAM read words
// Rev 1.0
// ============================================================================
module bram_rd_skid
    import bram_rd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rd_word_t         push_word,
    output logic             pop_valid,
    input  logic             pop_ready,
    output rd_word_t         pop_word,
    output logic [CNT_W-1:0] count
);

    rd_word_t         mem_q [FIFO_D];
    rd_word_t         mem_d [FIFO_D];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign pop       = pop_valid & pop_ready;
    assign pop_valid = (count_q != '0);
    assign pop_word  = mem_q[rd_ptr_q];
    assign count     = count_q;

    // The caller never pushes into a full buffer, so push is not gated here.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// bram_stream_reader : walks a base/length/stride window of an SB_RAM256x16
//                      and presents the words on a valid/ready stream
// Rev 1.0
// ============================================================================
module bram_stream_reader
    import bram_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [ADDR_W-1:0] stride,
    input  logic              loop,
    output logic [ADDR_W-1:0] raddr,
    output logic              read_en,
    output logic              rclke,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              loop_q, loop_d;
    logic              inflight_q, inflight_d;
    logic              tag_q, tag_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  fifo_count;
    rd_word_t          push_word;
    rd_word_t          pop_word;
    logic              pop;
    logic [2:0]        occupancy;
    logic              issue;
    logic              final_read;

    bram_rd_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_word (push_word),
        .pop_valid (m_valid),
        .pop_ready (m_ready),
        .pop_word  (pop_word),
        .count     (fifo_count)
    );

    assign push_word  = '{last: tag_q, data: rdata};
    assign m_data     = pop_word.data;
    assign m_last     = pop_word.last;
    assign pop        = m_valid & m_ready;

    // A word leaving this cycle frees its slot, which keeps one word per clock flowing.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == ST_RUN) && (occupancy < 3'd2);
    assign final_read = (remaining_q == LEN_W'(1));

    assign read_en    = issue;
    assign rclke      = issue;
    assign raddr      = addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        base_d      = base_q;
        stride_d    = stride_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        loop_d      = loop_q;
        tag_d       = tag_q;
        inflight_d  = issue;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = ST_RUN;
                        addr_d      = base_addr;
                        base_d      = base_addr;
                        stride_d    = stride;
                        remaining_d = length;
                        len_d       = length;
                        loop_d      = loop;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    tag_d = final_read;
                    if (final_read) begin
                        if (loop_q) begin
                            addr_d      = base_q;
                            remaining_d = len_q;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        addr_d      = addr_q + stride_q;
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                end
                if (stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (fifo_count == '0)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            inflight_q  <= 1'b0;
            tag_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            done_q      <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// tb_bram_stream_reader : directed bench with an SB_RAM256x16 read model
// Rev 1.0
// ============================================================================
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic        m_ready = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [8:0]  length = 9'd0;
    logic [7:0]  stride = 8'h00;
    logic [7:0]  raddr;
    logic        read_en;
    logic        rclke;
    logic [15:0] rdata = 16'h0000;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    bram_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .base_addr (base_addr),
        .length    (length),
        .stride    (stride),
        .loop      (loop),
        .raddr     (raddr),
        .read_en   (read_en),
        .rclke     (rclke),
        .rdata     (rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // RAM contents are mem[a] = {8'hA5, a}
    always @(posedge clk) begin
        if (read_en && rclke) rdata <= {8'hA5, raddr};
    end

    typedef struct packed {
        logic [7:0]       base;
        logic [8:0]       len;
        logic [7:0]       stride;
        logic             inj;
        logic [31:0]      rdy;
        logic [3:0]       n;
        logic [7:0]       last_mask;
        logic [7:0][15:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic [8:0] l, input logic [7:0] s,
                                input logic inj, input logic [31:0] rdy, input logic [3:0] n,
                                input logic [7:0] lm, input logic [127:0] d);
        vec_t v;
        v.base = b; v.len = l; v.stride = s; v.inj = inj; v.rdy = rdy;
        v.n = n; v.last_mask = lm; v.exp = d;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int          c, k, t_last, first_valid, outstanding;
        logic        held_v, held_l, pop, fin;
        logic [15:0] held_d;
        @(negedge clk);
        base_addr = v.base; length = v.len; stride = v.stride; loop = 1'b0;
        m_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0; k = 0; t_last = -1; first_valid = -1; outstanding = 0;
        held_v = 1'b0; held_l = 1'b0; held_d = 16'h0; fin = 1'b0;
        while (!fin && c < 120) begin
            start = v.inj && (c == 1);
            if (start) begin
                base_addr = 8'h00; length = 9'd8; stride = 8'h02; loop = 1'b1;
            end
            m_ready = (c < 32) ? v.rdy[c] : 1'b1;
            #1;
            if (c == 0) check({tag, " read_en one cycle after start"}, read_en, 1);
            if (m_valid && first_valid < 0) begin
                first_valid = c;
                check({tag, " first m_valid latency"}, c, 2);
            end
            if (held_v) begin
                check({tag, " m_valid held while stalled"}, m_valid, 1);
                check({tag, " m_data stable while stalled"}, m_data, held_d);
                check({tag, " m_last stable while stalled"}, m_last, held_l);
            end
            held_v = m_valid && !m_ready;
            held_d = m_data;
            held_l = m_last;
            pop = m_valid && m_ready;
            if (outstanding - int'(pop) >= 2) check({tag, " read_en low when buffer full"}, read_en, 0);
            if (read_en) outstanding++;
            if (pop) begin
                outstanding--;
                if (k < int'(v.n)) begin
                    check({tag, " m_data"}, m_data, v.exp[k]);
                    check({tag, " m_last"}, m_last, v.last_mask[k]);
                end else begin
                    check({tag, " unexpected extra word"}, m_data, 32'hFFFF_FFFF);
                end
                k++;
                if (k == int'(v.n)) t_last = c;
            end
            if (t_last >= 0 && c == t_last + 1) check({tag, " done not early"}, done, 0);
            if (t_last >= 0 && c == t_last + 2) begin
                check({tag, " done after last transfer"}, done, 1);
                check({tag, " busy cleared"}, busy, 0);
            end
            if (t_last >= 0 && c == t_last + 3) begin
                check({tag, " done single pulse"}, done, 0);
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                c++;
            end
        end
        check({tag, " completed in time"}, fin, 1);
        check({tag, " word count"}, k, v.n);
        start = 1'b0;
    endtask

    int          k, dones, i;
    logic        stop_sent, fin;
    logic [15:0] want;

    initial begin
        // Expected words: word 0 is the rightmost 16-bit field.
        vecs[0] = mk(8'h10, 9'd4, 8'h01, 1'b0, 32'hFFFF_FFFF, 4'd4, 8'h08,
                     {16'hA513, 16'hA512, 16'hA511, 16'hA510});
        vecs[1] = mk(8'hFE, 9'd4, 8'h01, 1'b0, 32'hFFFF_FFFF, 4'd4, 8'h08,
                     {16'hA501, 16'hA500, 16'hA5FF, 16'hA5FE});
        vecs[2] = mk(8'h00, 9'd8, 8'h01, 1'b0, 32'hFFFF_E055, 4'd8, 8'h80,
                     {16'hA507, 16'hA506, 16'hA505, 16'hA504, 16'hA503, 16'hA502, 16'hA501, 16'hA500});
        vecs[3] = mk(8'h30, 9'd5, 8'hF0, 1'b0, 32'hFFFF_FFF3, 4'd5, 8'h10,
                     {16'hA5F0, 16'hA500, 16'hA510, 16'hA520, 16'hA530});
        vecs[4] = mk(8'h80, 9'd1, 8'h07, 1'b0, 32'hFFFF_FFFF, 4'd1, 8'h01, {16'hA580});
        vecs[5] = mk(8'h50, 9'd3, 8'h01, 1'b1, 32'hFFFF_FFFF, 4'd3, 8'h04,
                     {16'hA552, 16'hA551, 16'hA550});
        vecs[6] = mk(8'h40, 9'd2, 8'h01, 1'b0, 32'hFFFF_FFFF, 4'd2, 8'h02, {16'hA541, 16'hA540});

        #2;
        check("reset raddr", raddr, 0);
        check("reset read_en", read_en, 0);
        check("reset rclke", rclke, 0);
        check("reset m_data", m_data, 0);
        check("reset m_valid", m_valid, 0);
        check("reset m_last", m_last, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Looping window aborted by stop after seven transfers
        @(negedge clk);
        base_addr = 8'h20; length = 9'd3; stride = 8'h10; loop = 1'b1; m_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
        k = 0; dones = 0; stop_sent = 1'b0; fin = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            stop = (k == 7) && !stop_sent;
            if (stop) stop_sent = 1'b1;
            #1;
            if (done) begin
                dones++;
                check("loop m_valid low at done", m_valid, 0);
            end
            if (m_valid && m_ready) begin
                want = (k % 3 == 0) ? 16'hA520 : (k % 3 == 1) ? 16'hA530 : 16'hA540;
                check("loop m_data", m_data, want);
                check("loop m_last", m_last, (k % 3 == 2));
                k++;
            end
            if (stop_sent && !busy && !done && dones > 0) fin = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        check("loop finished after stop", fin, 1);
        check("loop words delivered after stop", (k >= 8 && k <= 10), 1);
        check("loop done pulse count", dones, 1);
        check("loop busy cleared", busy, 0);

        // stop while idle has no effect
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        check("idle stop busy", busy, 0);
        check("idle stop done", done, 0);

        // zero length start: done pulse only
        @(negedge clk);
        base_addr = 8'h33; length = 9'd0; stride = 8'h01; start = 1'b1;
        #1;
        check("len0 read_en before edge", read_en, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0 done pulse", done, 1);
        check("len0 busy", busy, 0);
        check("len0 read_en", read_en, 0);
        @(negedge clk);
        #1;
        check("len0 done single", done, 0);
        check("len0 read_en later", read_en, 0);

        // asynchronous reset in the middle of a pass
        @(negedge clk);
        base_addr = 8'h00; length = 9'd8; stride = 8'h01; m_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        for (i = 0; i < 10 && !m_valid; i++) begin
            @(negedge clk);
            #1;
        end
        check("rst m_valid before reset", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst raddr", raddr, 0);
        check("rst read_en", read_en, 0);
        check("rst rclke", rclke, 0);
        check("rst m_data", m_data, 0);
        check("rst m_valid", m_valid, 0);
        check("rst m_last", m_last, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[6], "post-reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
